// File: rtl/pong_pkg.sv
// Shared encodings for the pong score keeper and the text overlay stage.
// Holds game state / winner codes, BCD digit width and a BCD-to-binary helper.
package pong_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Two-digit BCD pair to binary (0..99 fits in 7 bits).
  function automatic logic [6:0] bcd2bin(logic [DIGIT_W-1:0] tens, logic [DIGIT_W-1:0] ones);
    return (7'(tens) * 7'd10) + 7'(ones);
  endfunction

endpackage

// File: rtl/pong_score_if.sv
// Control and display bundle between the score keeper and its neighbours.
// master drives start/clr/points; slave (the score keeper) drives digits and status.
interface pong_score_if;
  import pong_pkg::*;

  logic               start;
  logic               clr;
  logic               point_l;
  logic               point_r;
  logic [DIGIT_W-1:0] dig0;
  logic [DIGIT_W-1:0] dig1;
  logic [DIGIT_W-1:0] dig2;
  logic [DIGIT_W-1:0] dig3;
  logic [1:0]         ball;
  logic [1:0]         game_state;
  logic [1:0]         winner;

  modport master (
    output start, clr, point_l, point_r,
    input  dig0, dig1, dig2, dig3, ball, game_state, winner
  );

  modport slave (
    input  start, clr, point_l, point_r,
    output dig0, dig1, dig2, dig3, ball, game_state, winner
  );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter: ones wrap 9->0 carrying into tens, saturates at 99.
// Synchronous active-high reset and clear both return the pair to 00.
module bcd2_counter
  import pong_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [DIGIT_W-1:0] ones_o
);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic               at_max;

  assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr_i) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc_i && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: rtl/pong_score_keeper.sv
// Pong game-progress tracker: BCD scores, balls remaining, IDLE/PLAY/OVER FSM and winner.
// Define PONG_SCORE_EDGE_EN to score on 0->1 transitions of level point inputs.
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 11,
  parameter int unsigned BALLS     = 3
) (
  input logic         clk,
  input logic         reset,
  pong_score_if.slave bus
);

  logic               qual_l, qual_r;
  logic               live, inc_l, inc_r, any_pt;
  logic [DIGIT_W-1:0] tens_l, ones_l, tens_r, ones_r;
  logic [6:0]         l_cur, r_cur, l_next, r_next;
  logic               hit_l, hit_r;
  logic [1:0]         ball_d;

  state_e     state_q;
  logic [1:0] ball_q;
  logic [1:0] winner_q;

`ifdef PONG_SCORE_EDGE_EN
  logic prev_l_q, prev_r_q;

  // Reset high so an input already asserted at reset release does not score.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_l_q <= 1'b1;
      prev_r_q <= 1'b1;
    end else begin
      prev_l_q <= bus.point_l;
      prev_r_q <= bus.point_r;
    end
  end

  assign qual_l = bus.point_l & ~prev_l_q;
  assign qual_r = bus.point_r & ~prev_r_q;
`else
  assign qual_l = bus.point_l;
  assign qual_r = bus.point_r;
`endif

  assign live   = (state_q == ST_PLAY) && !bus.clr;
  assign inc_l  = live && qual_l;
  assign inc_r  = live && qual_r;
  assign any_pt = inc_l || inc_r;

  bcd2_counter u_left (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (bus.clr),
    .inc_i  (inc_l),
    .tens_o (tens_l),
    .ones_o (ones_l)
  );

  bcd2_counter u_right (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (bus.clr),
    .inc_i  (inc_r),
    .tens_o (tens_r),
    .ones_o (ones_r)
  );

  // Win evaluation must see the post-increment scores in the same cycle.
  assign l_cur  = bcd2bin(tens_l, ones_l);
  assign r_cur  = bcd2bin(tens_r, ones_r);
  assign l_next = (inc_l && (l_cur != 7'd99)) ? l_cur + 7'd1 : l_cur;
  assign r_next = (inc_r && (r_cur != 7'd99)) ? r_cur + 7'd1 : r_cur;
  assign hit_l  = l_next >= 7'(WIN_SCORE);
  assign hit_r  = r_next >= 7'(WIN_SCORE);
  assign ball_d = (any_pt && (ball_q != 2'd0)) ? ball_q - 2'd1 : ball_q;

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      state_q  <= ST_IDLE;
      ball_q   <= 2'(BALLS);
      winner_q <= WIN_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          ball_q <= ball_d;
          if (hit_l || hit_r) begin
            state_q  <= ST_OVER;
            winner_q <= {hit_r, hit_l};
          end else if (any_pt && (ball_d == 2'd0)) begin
            state_q  <= ST_OVER;
            winner_q <= (l_next > r_next) ? WIN_L :
                        (r_next > l_next) ? WIN_R : WIN_DRAW;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dig0       = ones_l;
  assign bus.dig1       = tens_l;
  assign bus.dig2       = ones_r;
  assign bus.dig3       = tens_r;
  assign bus.ball       = ball_q;
  assign bus.game_state = state_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Self-checking bench for pong_score_keeper: directed vector table, held-input sequence,
// BCD counter carry/saturation walk and randomized play against a behavioural game model.
module tb_pong_score_keeper;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  pong_score_if bus_a ();
  pong_score_if bus_b ();

  pong_score_keeper #(.WIN_SCORE(11), .BALLS(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  // Low win threshold so score-based wins are reachable within three balls.
  pong_score_keeper #(.WIN_SCORE(2), .BALLS(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  logic       c_rst = 1'b1, c_clr = 1'b0, c_inc = 1'b0;
  logic [3:0] c_tens, c_ones;

  bcd2_counter u_cnt (
    .clk_i  (clk),
    .rst_i  (c_rst),
    .clr_i  (c_clr),
    .inc_i  (c_inc),
    .tens_o (c_tens),
    .ones_o (c_ones)
  );

  typedef struct {
    int l; int r; int ball; int st; int win; bit pl; bit pr;
  } mdl_t;

  typedef struct {
    bit rst; bit s; bit c; bit pl; bit pr;
    int l; int r; int ball; int st; int win;
  } vec_t;

  mdl_t ma, mb;
  vec_t tbl[$];

  function automatic mdl_t mstep(mdl_t m, int ws, int nb, bit rst, bit s, bit c, bit pl, bit pr);
    mdl_t n = m;
    bit ql, qr;
`ifdef PONG_SCORE_EDGE_EN
    ql = pl && !m.pl;
    qr = pr && !m.pr;
    n.pl = rst ? 1'b1 : pl;
    n.pr = rst ? 1'b1 : pr;
`else
    ql = pl;
    qr = pr;
`endif
    if (rst || c) begin
      n.l = 0; n.r = 0; n.ball = nb; n.st = 0; n.win = 0;
      return n;
    end
    if (m.st == 0) begin
      if (s) n.st = 1;
    end else if (m.st == 1 && (ql || qr)) begin
      if (ql && n.l < 99) n.l++;
      if (qr && n.r < 99) n.r++;
      if (n.ball > 0) n.ball--;
      if (n.l >= ws || n.r >= ws) begin
        n.st = 2;
        n.win = (n.l >= ws ? 1 : 0) + (n.r >= ws ? 2 : 0);
      end else if (n.ball == 0) begin
        n.st = 2;
        n.win = (n.l > n.r) ? 1 : (n.r > n.l) ? 2 : 3;
      end
    end
    return n;
  endfunction

  function automatic logic [21:0] pack(int l, int r, int ball, int st, int win);
    return {4'(r / 10), 4'(r % 10), 4'(l / 10), 4'(l % 10), 2'(ball), 2'(st), 2'(win)};
  endfunction

  function automatic logic [21:0] pack_a();
    return {bus_a.dig3, bus_a.dig2, bus_a.dig1, bus_a.dig0, bus_a.ball,
            bus_a.game_state, bus_a.winner};
  endfunction

  function automatic logic [21:0] pack_b();
    return {bus_b.dig3, bus_b.dig2, bus_b.dig1, bus_b.dig0, bus_b.ball,
            bus_b.game_state, bus_b.winner};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive on negedge, step models at posedge, compare both DUTs 1 unit later.
  task automatic tick(bit rst, bit s, bit c, bit pl, bit pr);
    @(negedge clk);
    reset = rst;
    bus_a.start = s; bus_a.clr = c; bus_a.point_l = pl; bus_a.point_r = pr;
    bus_b.start = s; bus_b.clr = c; bus_b.point_l = pl; bus_b.point_r = pr;
    @(posedge clk);
    ma = mstep(ma, 11, 3, rst, s, c, pl, pr);
    mb = mstep(mb, 2, 3, rst, s, c, pl, pr);
    #1;
    chk("model_a", 32'(pack_a()), 32'(pack(ma.l, ma.r, ma.ball, ma.st, ma.win)));
    chk("model_b", 32'(pack_b()), 32'(pack(mb.l, mb.r, mb.ball, mb.st, mb.win)));
  endtask

  initial begin
    bus_a.start = 0; bus_a.clr = 0; bus_a.point_l = 0; bus_a.point_r = 0;
    bus_b.start = 0; bus_b.clr = 0; bus_b.point_l = 0; bus_b.point_r = 0;
    ma = '{0, 0, 3, 0, 0, 1'b1, 1'b1};
    mb = ma;

    // BCD counter walk: carry at 9->10 and saturation at 99.
    @(negedge clk); c_rst = 1'b1;
    @(negedge clk); c_rst = 1'b0; c_inc = 1'b1;
    #1 chk("cnt_reset", {c_tens, c_ones}, 8'h00);
    for (int k = 1; k <= 102; k++) begin
      @(negedge clk);
      chk("cnt_inc", {c_tens, c_ones}, {4'((k > 99 ? 99 : k) / 10), 4'((k > 99 ? 99 : k) % 10)});
    end
    c_inc = 1'b0; c_clr = 1'b1;
    @(negedge clk);
    chk("cnt_clr", {c_tens, c_ones}, 8'h00);
    c_clr = 1'b0;

    //               rst s  c  pl pr   l  r  b  st w
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 3, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 3, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 1, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 2, 1, 0, 2, 1});
    tbl.push_back('{0, 1, 0, 0, 0, 2, 1, 0, 2, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 2, 1, 0, 2, 1});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 3, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 1, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 2, 2, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 2, 2, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 3, 3, 0, 2, 3});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 3, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0, 2, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 1, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 3, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 1, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 2, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 2, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 3, 0, 2, 2});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 3, 1, 0});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 3, 0, 0});

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].s, tbl[i].c, tbl[i].pl, tbl[i].pr);
      chk($sformatf("vec%0d", i), 32'(pack_a()),
          32'(pack(tbl[i].l, tbl[i].r, tbl[i].ball, tbl[i].st, tbl[i].win)));
    end

    // point_l held high for five cycles.
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick(0, 0, 0, 1, 0);
`ifdef PONG_SCORE_EDGE_EN
    chk("held_l", 32'(pack_a()), 32'(pack(1, 0, 2, 1, 0)));
`else
    chk("held_l", 32'(pack_a()), 32'(pack(3, 0, 0, 2, 1)));
`endif
    tick(0, 0, 0, 0, 0);

    for (int k = 0; k < 3000; k++) begin
      tick(($urandom_range(199) == 0), ($urandom_range(7) == 0), ($urandom_range(29) == 0),
           ($urandom_range(2) == 0), ($urandom_range(2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
